// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, framing and parity constants,
// and the 2-of-3 majority helper used by the oversampling voter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-controller bus: frame configuration in, received byte and
// one-cycle outcome strobes out.
interface uart_rx_if;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  modport master (
    input  PAR_EN, PAR_TYP,
    output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );

  modport slave (
    output PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority voter around mid-bit.
// bit_val is the vote, valid in the sample_done cycle (third sample).
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic start,
  input  logic run,
  input  logic rx_s,
  output logic bit_val,
  output logic sample_done,
  output logic bit_end
);

  localparam int unsigned CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] S0   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] S1   = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] S2   = CW'(PRESCALE / 2 + 1);

  logic [CW-1:0] edge_cnt;
  logic          smp0;
  logic          smp1;

  // The start-detect cycle is edge 0, so the counter restarts at 1 from it.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      edge_cnt <= '0;
      smp0     <= 1'b1;
      smp1     <= 1'b1;
    end else begin
      if (start)
        edge_cnt <= CW'(1);
      else if (run)
        edge_cnt <= (edge_cnt == LAST) ? '0 : edge_cnt + CW'(1);
      else
        edge_cnt <= '0;
      if (edge_cnt == S0) smp0 <= rx_s;
      if (edge_cnt == S1) smp1 <= rx_s;
    end
  end

  assign bit_val     = maj3(smp0, smp1, rx_s);
  assign sample_done = run && (edge_cnt == S2);
  assign bit_end     = run && (edge_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, framing FSM, shift register and checkers.
// Define UART_RX_PARITY_EN to build the PARITY state and PAR_ERR checker.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic      CLK,
  input  logic      RST_n,
  input  logic      RX_IN,
  uart_rx_if.master rx_bus
);

  rx_state_e  state;
  rx_state_e  state_nx;
  logic       rx_meta;
  logic       rx_s;
  logic       armed;
  logic       start_det;
  logic       run;
  logic       bit_val;
  logic       sample_done;
  logic       bit_end;
  logic       vote_q;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic       par_flag;
  logic       valid_nx;
  logic       perr_nx;
  logic       serr_nx;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_s    <= rx_meta;
    end
  end

  // armed remembers a high line; a stop bit voted high also arms it so a
  // start edge landing on the last stop sample is not lost. A break never arms.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      armed <= 1'b0;
    else if (start_det)
      armed <= 1'b0;
    else if ((state == IDLE) && rx_s)
      armed <= 1'b1;
    else if ((state == STOP) && sample_done && (bit_val == STOP_BIT))
      armed <= 1'b1;
  end

  assign start_det = (state == IDLE) && armed && (rx_s == START_BIT);
  assign run       = (state != IDLE);

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .start       (start_det),
    .run         (run),
    .rx_s        (rx_s),
    .bit_val     (bit_val),
    .sample_done (sample_done),
    .bit_end     (bit_end)
  );

`ifdef UART_RX_PARITY_EN
  logic par_en_q;
  logic par_typ_q;
  logic par_exp;

  assign par_exp = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_flag  <= 1'b0;
    end else if (start_det) begin
      par_en_q  <= rx_bus.PAR_EN;
      par_typ_q <= rx_bus.PAR_TYP;
      par_flag  <= 1'b0;
    end else if ((state == PARITY) && sample_done) begin
      par_flag  <= (bit_val != par_exp);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = rx_bus.PAR_EN ^ rx_bus.PAR_TYP;
  assign par_flag   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    valid_nx = 1'b0;
    perr_nx  = 1'b0;
    serr_nx  = 1'b0;
    case (state)
      IDLE:  if (start_det) state_nx = START;
      START: if (bit_end) state_nx = (vote_q == START_BIT) ? DATA : IDLE;
      DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nx = par_en_q ? PARITY : STOP;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_end) state_nx = STOP;
`endif
      STOP: begin
        if (sample_done) begin
          state_nx = IDLE;
          serr_nx  = (bit_val != STOP_BIT);
          perr_nx  = par_flag;
          valid_nx = (bit_val == STOP_BIT) && !par_flag;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vote_q            <= 1'b1;
      bit_cnt           <= '0;
      shift_q           <= '0;
      rx_bus.P_DATA     <= '0;
      rx_bus.DATA_VALID <= 1'b0;
      rx_bus.PAR_ERR    <= 1'b0;
      rx_bus.STP_ERR    <= 1'b0;
      rx_bus.Busy       <= 1'b0;
    end else begin
      if (sample_done) vote_q <= bit_val;
      if (start_det)
        bit_cnt <= '0;
      else if ((state == DATA) && bit_end)
        bit_cnt <= bit_cnt + 3'd1;
      if ((state == DATA) && sample_done) shift_q[bit_cnt] <= bit_val;
      if (valid_nx) rx_bus.P_DATA <= shift_q;
      rx_bus.DATA_VALID <= valid_nx;
      rx_bus.PAR_ERR    <= perr_nx;
      rx_bus.STP_ERR    <= serr_nx;
      rx_bus.Busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive half of the UART link in the low-power multi-clock processing system. It oversamples RX_IN on the UART clock domain and majority-votes each bit. It checks optional parity and stop bit, then delivers a parallel byte with a one-cycle valid strobe to the system controller. Its frame format matches the UART transmitter: start 0, LSB-first data, optional parity, stop 1.

## Interface
- PRESCALE, default 8: oversampling clocks per bit; legal values 8, 16, 32.
- CLK  input  1  UART clock, PRESCALE × baud.
- RST_n  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line, asynchronous to CLK, idles high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  1 = odd parity, 0 = even parity.
- P_DATA  output  8  received byte; holds its value between frames.
- DATA_VALID  output  1  one-cycle strobe: P_DATA holds a new error-free byte.
- PAR_ERR  output  1  one-cycle strobe: parity mismatch.
- STP_ERR  output  1  one-cycle strobe: stop bit sampled 0.
- Busy  output  1  high while the FSM is not in IDLE.

## Operation
- RX_IN passes through a 2-flop synchronizer (reset value 1). All logic below uses the synchronized bit rx_s.
- Edge counter runs 0..PRESCALE-1 within each bit. Bit counter tracks data bits 0..7.
- Samples are taken at edge counts PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The bit value is the 2-of-3 majority, valid after the third sample.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge of rx_s (previous 1, current 0). That cycle is edge 0 of the start bit. PAR_EN and PAR_TYP are latched on this cycle and held for the whole frame.
  - START: if the start bit votes 1 (glitch), go to IDLE at edge PRESCALE-1 and produce no output. Otherwise go to DATA at edge PRESCALE-1.
  - DATA: shift the voted bit into bit position [bit counter] (LSB first). After bit 7 reaches edge PRESCALE-1, go to PARITY if PAR_EN is latched, else go to STOP.
  - PARITY: expected parity = ^data for even, ~^data for odd. Set the internal parity-error flag on mismatch. Go to STOP at edge PRESCALE-1.
  - STOP: on the cycle after the third stop sample, return to IDLE and emit exactly one of two outcomes:
    - Error-free frame: DATA_VALID=1 and P_DATA is updated.
    - Errored frame: PAR_ERR and/or STP_ERR=1, DATA_VALID=0, P_DATA unchanged.
- Leaving STOP at mid-bit lets the FSM catch a back-to-back start edge.
- Break (line held low): the frame ends with STP_ERR. No new frame starts until rx_s returns to 1 and then falls again.
- A parity result with parity disabled is ignored.

## Timing
- Reset values: P_DATA=8'h00, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, Busy=0, FSM=IDLE.
- Reset asserted mid-frame aborts the frame immediately with no strobes.
- RX_IN fall to start detection: 2–3 CLK cycles (synchronizer).
- Start detection (edge 0) to output strobe, with N = 9 without parity or 10 with parity: N·PRESCALE + PRESCALE/2 + 2 cycles.
  - PRESCALE=8: 78 cycles without parity, 86 with parity.
- All outputs are registered. Strobes last exactly 1 cycle.
- Busy rises the cycle after start detection and falls together with the strobe.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state, parity checker and PAR_ERR are present, as described above.
- UART_RX_PARITY_EN undefined: PAR_EN and PAR_TYP are ignored, frames are always 10 bits (DATA → STOP), PAR_ERR is tied to 0, and the PARITY state is not generated.

## Structure
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP),
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1, shared with the transmitter,
  - the STOP_BIT=1 and START_BIT=0 constants.
- One sub-module, uart_rx_sampler: edge counter plus 3-sample majority voter. It outputs the voted bit, a sample_done pulse and a bit_end pulse. The FSM, shift register and checkers stay in uart_rx.

## Test plan
- PRESCALE=8, PAR_EN=1, PAR_TYP=1, send 0xA5 with odd parity bit 1 → DATA_VALID 86 cycles after start detection, P_DATA=0xA5, no errors.
- PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit forced to 1 → PAR_ERR pulse, DATA_VALID=0, P_DATA keeps its previous value.
- PAR_EN=0, send 0x81 with stop bit 0 → STP_ERR at cycle 78. Hold line low afterwards → no further frames until line goes high then low.
- 3-cycle low glitch on idle line → FSM returns to IDLE, no strobes, Busy high for one bit time only.
- Two frames 0x55 then 0xAA sent back-to-back with a single stop bit → two DATA_VALID pulses with correct bytes. Repeat with ±3% baud skew → same result.
- Assert RST_n low during data bit 4 → all outputs at reset values immediately. A subsequent 0x0F frame is received correctly.
